// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
//
// Parametrised RGB565 LCD/VGA raster timing generator with a
// latency-compensated pixel path. It runs on the pixel clock.
//
// Each line is ordered active, front porch, sync, back porch. Each frame uses
// the same order, counted in lines. Raw counters are presented early on
// LCD_X/LCD_Y so a pixel source can fetch data. The source answers DATA_LAT
// cycles later. All pin-side controls are delayed so that DE, HSYNC, VSYNC,
// the strobes and RGB change on the same edge, DATA_LAT+1 cycles after the
// coordinate was issued.
//
// Optional feature (compile-time macro LCD_TIMING_TESTPAT_EN):
//   Adds input test_sel. While test_sel is high, vga_datain is replaced by an
//   internal 8-bar colour pattern selected by h[BAR_LOG2+2:BAR_LOG2].
//
// Ports:
//   PixelClk     in   1   pixel clock
//   nRST         in   1   asynchronous active-low reset
//   run          in   1   enable; low parks the raster at (0,0), pins idle
//   test_sel     in   1   (LCD_TIMING_TESTPAT_EN only) colour-bar select
//   vga_datain   in  16   RGB565 pixel for coordinate issued DATA_LAT earlier
//   LCD_X/LCD_Y  out 16   raw request-side horizontal/vertical counters
//   req_active   out  1   LCD_X/LCD_Y lie inside the visible area
//   LCD_DE       out  1   aligned data enable
//   LCD_HSYNC    out  1   aligned HSYNC, level set by HS_POL
//   LCD_VSYNC    out  1   aligned VSYNC, level set by VS_POL
//   LCD_R/G/B    out 5/6/5 aligned pixel, zero whenever LCD_DE is 0
//   frame_start  out  1   pin-aligned strobe on pixel (0,0)
//   line_start   out  1   pin-aligned strobe on pixel 0 of every line
//   frame_cnt    out  8   completed frames, request-side aligned, wraps
//
// DATA_LAT must lie in 0..4.
// ---------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 32,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int DATA_LAT = 1,
    parameter int BAR_LOG2 = 7
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        run,
`ifdef LCD_TIMING_TESTPAT_EN
    input  logic        test_sel,
`endif
    input  logic [15:0] vga_datain,
    output logic [15:0] LCD_X,
    output logic [15:0] LCD_Y,
    output logic        req_active,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        frame_start,
    output logic        line_start,
    output logic [7:0]  frame_cnt
);

    // Raster boundaries, all held in the 16-bit counter width.
    localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] H_HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] V_VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Control bundle carried down the alignment pipeline.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } ctrl_t;

    // Idle/reset value: DE and strobes low, syncs at their inactive level.
    localparam ctrl_t CTRL_IDLE = '{de: 1'b0, hs: ~HS_ON, vs: ~VS_ON,
                                    ls: 1'b0, fs: 1'b0};

    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic [7:0]  frame_q;
    logic        h_last;
    logic        v_last;
    logic        h_vis;
    logic        v_vis;
    logic        hs_act;
    logic        vs_act;
    ctrl_t       pre;
    ctrl_t       pipe [0:DATA_LAT];
    logic        de_into_last;
    logic [15:0] pix_next;
    logic [15:0] pix_q;

    assign h_last = (h_cnt == H_TOTAL - 16'd1);
    assign v_last = (v_cnt == V_TOTAL - 16'd1);

    // Raster counters. Dropping run parks the raster at (0,0), so the next
    // rise of run always begins a clean frame. frame_cnt counts on the same
    // edge as the frame wrap.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            frame_q <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
                v_cnt   <= '0;
                frame_q <= frame_q + 8'd1;
            end else begin
                v_cnt <= v_cnt + 16'd1;
            end
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    // Pre-stage controls decoded from the live counters. Gating with run
    // makes the pins go idle exactly DATA_LAT+1 cycles after run falls. A
    // zero-width sync gives an empty compare window and is never asserted.
    always_comb begin
        h_vis  = (h_cnt < H_VIS);
        v_vis  = (v_cnt < V_VIS);
        hs_act = run && (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
        vs_act = run && (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);

        pre    = CTRL_IDLE;
        pre.de = run && h_vis && v_vis;
        pre.hs = ~(hs_act ^ HS_ON);
        pre.vs = ~(vs_act ^ VS_ON);
        pre.ls = run && (h_cnt == 16'd0);
        pre.fs = run && (h_cnt == 16'd0) && (v_cnt == 16'd0);
    end

    // Alignment shift register, DATA_LAT+1 stages deep. Stage DATA_LAT
    // drives the pins.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i <= DATA_LAT; i++) begin
                pipe[i] <= CTRL_IDLE;
            end
        end else begin
            pipe[0] <= pre;
            for (int i = 1; i <= DATA_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // DE value that lands on the pin at the same edge the pixel register
    // loads. Gating the pixel with it keeps RGB at 0 outside DE without any
    // logic after the output flops.
    generate
        if (DATA_LAT == 0) begin : g_de_lat0
            assign de_into_last = pre.de;
        end else begin : g_de_latn
            assign de_into_last = pipe[DATA_LAT-1].de;
        end
    endgenerate

`ifdef LCD_TIMING_TESTPAT_EN
    // Colour bars from the request-side h counter. The bar word and its
    // select travel DATA_LAT stages so they meet the pixel register together
    // with the source data they replace.
    logic [2:0]  bar_idx;
    logic [15:0] bar_pix;
    logic        sel_last;
    logic [15:0] bar_last;

    assign bar_idx = h_cnt[BAR_LOG2+2 -: 3];
    assign bar_pix = {(bar_idx[2] ? 5'h1F : 5'h00),
                      (bar_idx[1] ? 6'h3F : 6'h00),
                      (bar_idx[0] ? 5'h1F : 5'h00)};

    generate
        if (DATA_LAT == 0) begin : g_pat_lat0
            assign sel_last = test_sel;
            assign bar_last = bar_pix;
        end else begin : g_pat_latn
            logic [16:0] pat_q [0:DATA_LAT-1];

            // Delay line for the pattern word and its select flag.
            always_ff @(posedge PixelClk or negedge nRST) begin
                if (!nRST) begin
                    for (int i = 0; i < DATA_LAT; i++) begin
                        pat_q[i] <= '0;
                    end
                end else begin
                    pat_q[0] <= {test_sel, bar_pix};
                    for (int i = 1; i < DATA_LAT; i++) begin
                        pat_q[i] <= pat_q[i-1];
                    end
                end
            end

            assign {sel_last, bar_last} = pat_q[DATA_LAT-1];
        end
    endgenerate

    // Pixel source select and blanking.
    always_comb begin
        pix_next = '0;
        if (de_into_last) begin
            pix_next = sel_last ? bar_last : vga_datain;
        end
    end
`else
    // Pixel blanking: RGB follows the source only while DE is active.
    always_comb begin
        pix_next = '0;
        if (de_into_last) begin
            pix_next = vga_datain;
        end
    end
`endif

    // Single pixel register; it loads on the same edge as the last control
    // stage so RGB and the controls switch together.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_next;
        end
    end

    assign LCD_X       = h_cnt;
    assign LCD_Y       = v_cnt;
    assign req_active  = h_vis && v_vis;
    assign frame_cnt   = frame_q;

    assign LCD_DE      = pipe[DATA_LAT].de;
    assign LCD_HSYNC   = pipe[DATA_LAT].hs;
    assign LCD_VSYNC   = pipe[DATA_LAT].vs;
    assign line_start  = pipe[DATA_LAT].ls;
    assign frame_start = pipe[DATA_LAT].fs;

    assign LCD_R       = pix_q[15:11];
    assign LCD_G       = pix_q[10:5];
    assign LCD_B       = pix_q[4:0];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_gen
//
// Directed self-checking bench for lcd_timing_gen. It uses a reduced raster
// (25 x 10 totals) so that whole frames stay short. HSYNC is active-low,
// VSYNC is active-high, and DATA_LAT is 2. The bench plays the pixel source:
// it returns {Y[7:0], X[7:0]} of its own coordinate sequence DATA_LAT cycles
// after that coordinate was issued.
// ---------------------------------------------------------------------------
module tb_lcd_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int HS_POL   = 0;
    localparam int VS_POL   = 1;
    localparam int DATA_LAT = 2;
    localparam int BAR_LOG2 = 2;
    localparam int H_TOTAL  = 25;
    localparam int V_TOTAL  = 10;

    logic        clk = 1'b0;
    logic        nrst;
    logic        run;
    logic        test_sel;
    logic [15:0] vga_datain;
    logic [15:0] lcd_x;
    logic [15:0] lcd_y;
    logic        req_active;
    logic        lcd_de;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        frame_start;
    logic        line_start;
    logic [7:0]  frame_cnt;

    // One issued request per cycle: was the raster running, was the bar
    // pattern selected, and which coordinate sat on LCD_X/LCD_Y.
    typedef struct {
        bit valid;
        bit sel;
        int h;
        int v;
    } req_t;

    req_t hist[$];
    int   cur_h;
    int   cur_v;
    int   exp_fc;
    int   tests;
    int   fails;
    int   de_cnt;
    int   hs_low_cnt;
    int   vs_high_cnt;
    int   ls_cnt;
    int   fs_cnt;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .DATA_LAT (DATA_LAT),
        .BAR_LOG2 (BAR_LOG2)
    ) dut (
        .PixelClk    (clk),
        .nRST        (nrst),
        .run         (run),
`ifdef LCD_TIMING_TESTPAT_EN
        .test_sel    (test_sel),
`endif
        .vga_datain  (vga_datain),
        .LCD_X       (lcd_x),
        .LCD_Y       (lcd_y),
        .req_active  (req_active),
        .LCD_DE      (lcd_de),
        .LCD_HSYNC   (lcd_hsync),
        .LCD_VSYNC   (lcd_vsync),
        .LCD_R       (lcd_r),
        .LCD_G       (lcd_g),
        .LCD_B       (lcd_b),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_cnt   (frame_cnt)
    );

    // Single comparison point: counts the test and reports any miss.
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Colour-bar word for a given horizontal position.
    function automatic logic [15:0] bar_word(input int h);
        logic [31:0] hv;
        logic [2:0]  b;
        hv = 32'(h);
        b  = hv[BAR_LOG2+2 -: 3];
        return {(b[2] ? 5'h1F : 5'h00), (b[1] ? 6'h3F : 6'h00),
                (b[0] ? 5'h1F : 5'h00)};
    endfunction

    // Forget all history: the DUT pipeline holds idle entries after reset.
    task automatic clearHistory();
        req_t idle;
        idle.valid = 1'b0;
        idle.sel   = 1'b0;
        idle.h     = 0;
        idle.v     = 0;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            hist.push_back(idle);
        end
        cur_h  = 0;
        cur_v  = 0;
        exp_fc = 0;
    endtask

    // Checks the request side against the expected counters, and the pins
    // against the request issued DATA_LAT+1 cycles earlier.
    task automatic checkOutput();
        req_t        r;
        logic        exp_de;
        logic        exp_hs;
        logic        exp_vs;
        logic        exp_ls;
        logic        exp_fs;
        logic        hs_act;
        logic        vs_act;
        logic [15:0] exp_pix;
        logic [31:0] hv;
        logic [31:0] vv;

        check("LCD_X", 32'(lcd_x), 32'(cur_h));
        check("LCD_Y", 32'(lcd_y), 32'(cur_v));
        check("req_active", 32'(req_active),
              32'(cur_h < H_ACTIVE && cur_v < V_ACTIVE));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_fc % 256));

        r       = hist[hist.size()-1-DATA_LAT];
        exp_de  = 1'b0;
        exp_hs  = (HS_POL == 0);
        exp_vs  = (VS_POL == 0);
        exp_ls  = 1'b0;
        exp_fs  = 1'b0;
        exp_pix = 16'h0000;
        if (r.valid) begin
            hs_act = (r.h >= H_ACTIVE + H_FP) && (r.h < H_ACTIVE + H_FP + H_SYNC);
            vs_act = (r.v >= V_ACTIVE + V_FP) && (r.v < V_ACTIVE + V_FP + V_SYNC);
            exp_de = (r.h < H_ACTIVE) && (r.v < V_ACTIVE);
            exp_hs = (HS_POL != 0) ? hs_act : !hs_act;
            exp_vs = (VS_POL != 0) ? vs_act : !vs_act;
            exp_ls = (r.h == 0);
            exp_fs = (r.h == 0) && (r.v == 0);
            hv     = 32'(r.h);
            vv     = 32'(r.v);
            if (exp_de) begin
                exp_pix = r.sel ? bar_word(r.h) : {vv[7:0], hv[7:0]};
            end
        end
        check("LCD_DE", 32'(lcd_de), 32'(exp_de));
        check("LCD_HSYNC", 32'(lcd_hsync), 32'(exp_hs));
        check("LCD_VSYNC", 32'(lcd_vsync), 32'(exp_vs));
        check("line_start", 32'(line_start), 32'(exp_ls));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("LCD_RGB", 32'({lcd_r, lcd_g, lcd_b}), 32'(exp_pix));
    endtask

    // One pixel cycle: check at the falling edge, then drive run/test_sel,
    // answer the source request from DATA_LAT cycles ago, and advance the
    // expected counters.
    task automatic applyStimulus(input logic run_val, input logic sel_val);
        req_t        r;
        req_t        src;
        logic [31:0] hv;
        logic [31:0] vv;

        @(negedge clk);
        checkOutput();
        run      = run_val;
        test_sel = sel_val;
        r.valid  = run_val;
        r.sel    = test_sel;
        r.h      = cur_h;
        r.v      = cur_v;
        hist.push_back(r);
        src        = hist[hist.size()-1-DATA_LAT];
        hv         = 32'(src.h);
        vv         = 32'(src.v);
        vga_datain = {vv[7:0], hv[7:0]};
        if (run_val) begin
            if (cur_h == H_TOTAL - 1) begin
                cur_h = 0;
                if (cur_v == V_TOTAL - 1) begin
                    cur_v = 0;
                    exp_fc++;
                end else begin
                    cur_v++;
                end
            end else begin
                cur_h++;
            end
        end else begin
            cur_h = 0;
            cur_v = 0;
        end
        if (hist.size() > 16) begin
            void'(hist.pop_front());
        end
    endtask

    // Reset values after an asynchronous reset with no clock edge needed.
    task automatic checkResetValues(input string tag);
        check({tag, "_X"}, 32'(lcd_x), 32'd0);
        check({tag, "_Y"}, 32'(lcd_y), 32'd0);
        check({tag, "_DE"}, 32'(lcd_de), 32'd0);
        check({tag, "_HSYNC"}, 32'(lcd_hsync), 32'd1);
        check({tag, "_VSYNC"}, 32'(lcd_vsync), 32'd0);
        check({tag, "_RGB"}, 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_line_start"}, 32'(line_start), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        de_cnt      = 0;
        hs_low_cnt  = 0;
        vs_high_cnt = 0;
        ls_cnt      = 0;
        fs_cnt      = 0;
        nrst        = 1'b0;
        run         = 1'b0;
        test_sel    = 1'b0;
        vga_datain  = 16'h0000;
        clearHistory();

        // Power-on reset: everything at reset values, syncs inactive.
        #23;
        checkResetValues("por");

        // Release reset with run low: raster parked, pins idle.
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
        end

        // Two full frames plus the pipeline tail.
        for (int i = 0; i < 2 * H_TOTAL * V_TOTAL + DATA_LAT + 1; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (lcd_de === 1'b1)      de_cnt++;
            if (lcd_hsync === 1'b0)   hs_low_cnt++;
            if (lcd_vsync === 1'b1)   vs_high_cnt++;
            if (line_start === 1'b1)  ls_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        check("de_cycles_2frames", 32'(de_cnt), 32'd192);
        check("hsync_low_cycles", 32'(hs_low_cnt), 32'd60);
        check("vsync_high_cycles", 32'(vs_high_cnt), 32'd100);
        check("line_start_count", 32'(ls_cnt), 32'd20);
        check("frame_start_count", 32'(fs_cnt), 32'd2);
        check("frame_cnt_after_2", 32'(frame_cnt), 32'd2);

        // Advance to (h=10, v=3), then drop run for 10 cycles.
        for (int i = 0; i < 82; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        check("drop_de_still_on", 32'(lcd_de), 32'd1);
        applyStimulus(1'b0, 1'b0);
        check("drop_de_off", 32'(lcd_de), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0);
        end
        check("drop_frame_cnt_kept", 32'(frame_cnt), 32'd2);

        // Raise run: clean frame, frame_start on the pins DATA_LAT+1 later.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        check("rise_fs_not_yet", 32'(frame_start), 32'd0);
        applyStimulus(1'b1, 1'b0);
        check("rise_fs_on_pins", 32'(frame_start), 32'd1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        check("pre_reset_de", 32'(lcd_de), 32'd1);

        // Asynchronous reset mid-line, checked before any clock edge.
        #2;
        nrst = 1'b0;
        run  = 1'b0;
        #1;
        checkResetValues("async");
        clearHistory();
        @(negedge clk);
        nrst = 1'b1;

        // Restart from reset with data path.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0);
        end

`ifdef LCD_TIMING_TESTPAT_EN
        // Colour bars replace the source data while test_sel is high.
        for (int i = 0; i < 2 * H_TOTAL; i++) begin
            applyStimulus(1'b1, 1'b1);
        end
        for (int i = 0; i < H_TOTAL; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
`endif

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB565 LCD/VGA raster timing generator with a latency-compensated pixel path. It runs on the pixel clock between the frame-buffer/pixel source and the LCD pins. It issues pixel coordinates ahead of time, accepts the source's pixel data a fixed `DATA_LAT` cycles later, and re-aligns DE, HSYNC, VSYNC and RGB so that all pin outputs change on the same edge. It adds the separate sync/porch timing, sync polarity, run control and frame/line strobes that the fixed 1024x600 generator lacks.

## Interface
- Clock is `PixelClk`. Reset is `nRST`, asynchronous and active-low.
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 48: HSYNC width, in pixels.
- `H_BP`, 88: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 13: vertical front porch, in lines.
- `V_SYNC`, 3: VSYNC width, in lines.
- `V_BP`, 32: vertical back porch, in lines.
- `HS_POL`, 0: HSYNC active level (1 = active-high).
- `VS_POL`, 0: VSYNC active level (1 = active-high).
- `DATA_LAT`, 1: pixel-source read latency in cycles; legal range 0..4.
- `BAR_LOG2`, 7: log2 of the test-pattern bar width.
- `PixelClk`  in  1  pixel clock.
- `nRST`  in  1  asynchronous active-low reset.
- `run`  in  1  enable; while low the raster parks at (0,0) with outputs inactive.
- `vga_datain`  in  16  RGB565 pixel for the coordinate issued `DATA_LAT` cycles earlier.
- `LCD_X`, `LCD_Y`  out  16 each  raw horizontal/vertical counters (request side, not delayed).
- `req_active`  out  1  `LCD_X`/`LCD_Y` lie in the visible area.
- `LCD_DE`, `LCD_HSYNC`, `LCD_VSYNC`  out  1 each  registered, aligned pin controls.
- `LCD_R` 5, `LCD_G` 6, `LCD_B` 5  out  registered pixel; zero whenever `LCD_DE` is 0.
- `frame_start`, `line_start`  out  1 each  one-cycle strobes, aligned with the pins.
- `frame_cnt`  out  8  completed-frame count; wraps 255 -> 0.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way. Both counters are 16 bits wide.
- Each line is ordered active, front porch, sync, back porch. Frames use the same order in lines.
- With `run` high, `h` increments every cycle.
  - At h = H_TOTAL-1, `h` wraps to 0 and `v` increments.
  - At v = V_TOTAL-1 with h = H_TOTAL-1, `v` wraps to 0 and `frame_cnt` increments.
- With `run` low, h = v = 0 on the next edge. The pre-stage controls are forced inactive: DE 0, syncs at their inactive levels, strobes 0.
- Pre-stage signals, computed from the current counters:
  - DE is active when h < H_ACTIVE and v < V_ACTIVE.
  - HS is active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - VS is active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. VS therefore changes only at a line wrap.
  - line_start = (h == 0). frame_start = (h == 0 && v == 0).
- Each sync's output level is its active flag XNOR its polarity parameter. Reset and idle drive the inactive level, i.e. the inverse of the polarity parameter.
- All pre-stage controls pass through a DATA_LAT+1 stage shift register. `vga_datain` is registered once. RGB = DE ? data : 0.

## Timing
- Reset clears the counters, `frame_cnt`, every delay stage and RGB. The pins then read DE 0, syncs inactive, RGB 0 and strobes 0.
- A coordinate presented on `LCD_X`/`LCD_Y` at cycle t appears on the pins at cycle t+DATA_LAT+1 together with its data.
- On the first active edge after reset release with `run` high, the counters read (0,0). The first `frame_start` reaches the pins DATA_LAT+1 cycles later.
- When `run` falls mid-frame, the pins go inactive DATA_LAT+1 cycles later. The next rise of `run` starts a clean frame at (0,0).
- `frame_cnt` updates on the same edge as the frame wrap, i.e. it is request-side aligned.
- Porch or sync parameters may be 0. A zero-width sync is never asserted.

## Configuration
- `LCD_TIMING_TESTPAT_EN` defined:
  - Adds an input `test_sel` (1 bit).
  - While `test_sel` is high, `vga_datain` is ignored and an internal colour-bar pattern is substituted.
  - Bar index b = h[BAR_LOG2+2:BAR_LOG2]. R = b[2] ? 5'h1F : 0. G = b[1] ? 6'h3F : 0. B = b[0] ? 5'h1F : 0.
  - The pattern is delayed to match the pin alignment.
- Undefined: no `test_sel` port and no pattern logic; the RGB path is `vga_datain` only.

## Test plan
- Defaults, `run` held high, two frames: exactly 976 cycles per HSYNC period and 528 lines per VSYNC period; 800 DE cycles per visible line; 480 visible lines; HSYNC low for 48 cycles beginning 840 cycles after each line's first DE.
- DATA_LAT=3, source returns {LCD_Y[7:0], LCD_X[7:0]} with a 3-cycle delay: every DE=1 pin pixel equals {Y,X} of that position; RGB is 0 during blanking.
- HS_POL=1, VS_POL=1: during reset and idle both syncs read 0; VSYNC is high for 3 lines.
- `run` dropped at h=300, v=100, then raised 10 cycles later: pins are inactive DATA_LAT+1 cycles after the drop; the next `frame_start` appears DATA_LAT+1 cycles after the rise; `frame_cnt` is unchanged.
- `nRST` asserted mid-line: all outputs reach their reset values immediately, without waiting for a clock edge; `frame_cnt` reads 0.
- With `LCD_TIMING_TESTPAT_EN` defined and `test_sel`=1: pixels 0..127 are 0x0000, pixels 128..255 are 0x001F, and pixels 896..1023 would be 0xFFFF (unreachable when H_ACTIVE=800; set H_ACTIVE=1024 to check).
